conv_param_loader: RTL and testbench

- Sequencer that fills the combined conv weight RAM (L1+L2, 4752 bytes) and the combined conv bias RAM (48 x 32-bit) from a single byte stream, e.g. the UART receiver.
- Sits between the byte source and the write ports of both RAMs.
- Asserts done once every parameter is written, so the inference FSM may start.

---
 rtl/conv_param_loader.sv | 120 ++++++++++++
 tb/tb_conv_param_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_param_loader.sv
// conv_param_loader: streams conv weights and biases from a byte source into
// the combined weight RAM (byte-wide) and bias RAM (32-bit words), then holds
// done until the next start. Bias words are assembled little-endian.
module conv_param_loader #(
  parameter int W_BYTES = 4752,
  parameter int B_WORDS = 48,
  parameter int WA_W    = 13,
  parameter int BA_W    = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic [WA_W-1:0] w_wr_addr,
  output logic [7:0]      w_wr_data,
  output logic            w_wr_en,
  output logic [BA_W-1:0] b_wr_addr,
  output logic [31:0]     b_wr_data,
  output logic            b_wr_en,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_B = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [WA_W-1:0] W_LAST = WA_W'(W_BYTES - 1);
  localparam logic [BA_W-1:0] B_LAST = BA_W'(B_WORDS - 1);

  state_t          state;
  logic [WA_W-1:0] w_cnt;
  logic [BA_W-1:0] b_cnt;
  logic [1:0]      lane;
  logic [23:0]     held;

  // Load sequencer: counters, bias byte assembly and registered RAM strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      w_cnt     <= '0;
      b_cnt     <= '0;
      lane      <= '0;
      held      <= '0;
      w_wr_addr <= '0;
      w_wr_data <= '0;
      w_wr_en   <= 1'b0;
      b_wr_addr <= '0;
      b_wr_data <= '0;
      b_wr_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses; addresses and data hold otherwise.
      w_wr_en <= 1'b0;
      b_wr_en <= 1'b0;

      if (start) begin
        // Start always wins: (re)arm a full load and drop any byte this cycle.
        state <= LOAD_W;
        w_cnt <= '0;
        b_cnt <= '0;
        lane  <= '0;
        held  <= '0;
        busy  <= 1'b1;
        done  <= 1'b0;
      end else begin
        case (state)
          LOAD_W: begin
            if (in_valid) begin
              w_wr_addr <= w_cnt;
              w_wr_data <= in_data;
              w_wr_en   <= 1'b1;
              if (w_cnt == W_LAST) begin
                // Stop counting at the last weight so no address past the RAM appears.
                state <= LOAD_B;
                b_cnt <= '0;
                lane  <= '0;
              end else begin
                w_cnt <= w_cnt + 1'b1;
              end
            end
          end

          LOAD_B: begin
            if (in_valid) begin
              if (lane != 2'd3) begin
                // Shift in from the top so byte 0 ends up in bits [7:0].
                held <= {in_data, held[23:8]};
                lane <= lane + 1'b1;
              end else begin
                b_wr_addr <= b_cnt;
                b_wr_data <= {in_data, held};
                b_wr_en   <= 1'b1;
                lane      <= '0;
                if (b_cnt == B_LAST) begin
                  // done rises together with the final bias strobe.
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  b_cnt <= b_cnt + 1'b1;
                end
              end
            end
          end

          default: begin
            // IDLE and DONE ignore the stream.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_param_loader.sv
// Directed bench for conv_param_loader: reset, full load, latency/gaps,
// partial bias stall, restart mid-load and post-done behaviour.
module tb_conv_param_loader;

  localparam int W_BYTES = 4752;
  localparam int B_WORDS = 48;
  localparam int WA_W    = 13;
  localparam int BA_W    = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [7:0]      in_data;
  logic            in_valid;
  logic [WA_W-1:0] w_wr_addr;
  logic [7:0]      w_wr_data;
  logic            w_wr_en;
  logic [BA_W-1:0] b_wr_addr;
  logic [31:0]     b_wr_data;
  logic            b_wr_en;
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_fail   = 0;

  conv_param_loader #(
    .W_BYTES(W_BYTES), .B_WORDS(B_WORDS), .WA_W(WA_W), .BA_W(BA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data), .w_wr_en(w_wr_en),
    .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data), .b_wr_en(b_wr_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_w_en"}, 32'(w_wr_en), 0);
    check_eq({tag, "_w_addr"}, 32'(w_wr_addr), 0);
    check_eq({tag, "_w_data"}, 32'(w_wr_data), 0);
    check_eq({tag, "_b_en"}, 32'(b_wr_en), 0);
    check_eq({tag, "_b_addr"}, 32'(b_wr_addr), 0);
    check_eq({tag, "_b_data"}, b_wr_data, 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("start_busy", 32'(busy), 1);
    check_eq("start_done", 32'(done), 0);
    check_eq("start_w_en", 32'(w_wr_en), 0);
    check_eq("start_b_en", 32'(b_wr_en), 0);
  endtask

  // One weight byte: write must appear exactly one cycle after acceptance.
  task automatic send_w(input logic [7:0] d, input int addr);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    check_eq("w_en", 32'(w_wr_en), 1);
    check_eq("w_addr", 32'(w_wr_addr), 32'(addr));
    check_eq("w_data", 32'(w_wr_data), 32'(d));
    check_eq("b_en_during_w", 32'(b_wr_en), 0);
  endtask

  task automatic send_b_byte(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    check_eq("w_en_during_b", 32'(w_wr_en), 0);
  endtask

  task automatic check_bias_write(input logic [31:0] word, input int addr);
    check_eq("b_en", 32'(b_wr_en), 1);
    check_eq("b_addr", 32'(b_wr_addr), 32'(addr));
    check_eq("b_data", b_wr_data, word);
    check_eq("b_done_edge", 32'(done), (addr == B_WORDS - 1) ? 1 : 0);
    check_eq("b_busy_edge", 32'(busy), (addr == B_WORDS - 1) ? 0 : 1);
  endtask

  task automatic send_word(input logic [31:0] word, input int addr);
    for (int l = 0; l < 3; l++) begin
      send_b_byte(word[8*l +: 8]);
      check_eq("b_en_early", 32'(b_wr_en), 0);
    end
    send_b_byte(word[31:24]);
    check_bias_write(word, addr);
  endtask

  task automatic load_weights(input int from, input int to);
    for (int i = from; i < to; i++) send_w(8'(i), i);
  endtask

  // Bias bytes run 0x00..0xBF, so word k = {4k+3, 4k+2, 4k+1, 4k}.
  task automatic load_bias(input int from);
    for (int k = from; k < B_WORDS; k++)
      send_word({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}, k);
    step();
    check_eq("after_done", 32'(done), 1);
    check_eq("after_busy", 32'(busy), 0);
    check_eq("after_b_en", 32'(b_wr_en), 0);
    check_eq("after_w_en", 32'(w_wr_en), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #11;
    check_all_zero("por");
    #1 rst_n = 1'b1;
    step();

    // Reset mid-load clears everything asynchronously.
    pulse_start();
    send_w(8'h12, 0);
    send_w(8'h34, 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    #2 rst_n = 1'b1;
    step();
    // Bytes without start are ignored.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hC0 + i);
      step();
      check_eq("idle_w_en", 32'(w_wr_en), 0);
      check_eq("idle_b_en", 32'(b_wr_en), 0);
      check_eq("idle_done", 32'(done), 0);
      check_eq("idle_busy", 32'(busy), 0);
    end
    in_valid = 1'b0;

    // Full back-to-back load; word 0 = 0x03020100, word 47 = 0xBFBEBDBC.
    pulse_start();
    load_weights(0, W_BYTES);
    load_bias(0);

    // Latency and gaps, started from DONE.
    pulse_start();
    send_w(8'h5A, 0);
    for (int i = 0; i < 7; i++) begin
      step();
      check_eq("gap_w_en", 32'(w_wr_en), 0);
      check_eq("gap_w_data_hold", 32'(w_wr_data), 32'h5A);
      check_eq("gap_w_addr_hold", 32'(w_wr_addr), 0);
    end
    send_w(8'hA5, 1);
    load_weights(2, W_BYTES);

    // Partial bias word held across a long stall.
    send_b_byte(8'hAA);
    check_eq("part_b_en0", 32'(b_wr_en), 0);
    send_b_byte(8'hBB);
    check_eq("part_b_en1", 32'(b_wr_en), 0);
    for (int i = 0; i < 100; i++) begin
      step();
      check_eq("stall_b_en", 32'(b_wr_en), 0);
    end
    send_b_byte(8'h11);
    check_eq("part_b_en2", 32'(b_wr_en), 0);
    send_b_byte(8'h22);
    check_bias_write(32'h2211BBAA, 0);
    step();
    check_eq("part_single_pulse", 32'(b_wr_en), 0);
    load_bias(1);

    // Restart mid-load with a coincident valid byte.
    pulse_start();
    load_weights(0, 300);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    step();
    start    = 1'b0;
    in_valid = 1'b0;
    check_eq("restart_w_en", 32'(w_wr_en), 0);
    check_eq("restart_busy", 32'(busy), 1);
    check_eq("restart_done", 32'(done), 0);
    load_weights(0, W_BYTES);
    load_bias(0);

    // Post-done: bytes dropped, then start with a coincident byte.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hE0 + i);
      step();
      check_eq("post_w_en", 32'(w_wr_en), 0);
      check_eq("post_b_en", 32'(b_wr_en), 0);
      check_eq("post_done", 32'(done), 1);
    end
    start   = 1'b1;
    in_data = 8'h99;
    step();
    start    = 1'b0;
    in_valid = 1'b0;
    check_eq("post_start_done", 32'(done), 0);
    check_eq("post_start_busy", 32'(busy), 1);
    check_eq("post_start_w_en", 32'(w_wr_en), 0);
    send_w(8'h3C, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
